// File: rtl/slon5_collect.sv
// Result collector for the slon5 core: a DEPTH-entry FIFO with a registered head
// entry, sticky overflow, and a tag-sequence tracker on the raw core output stream.
module slon5_collect #(
  parameter int DOUT_W = 32,
  parameter int DNUM_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DOUT_W-1:0]          in_dout,
  input  logic [DNUM_W-1:0]          in_dnum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DOUT_W-1:0]          out_dout,
  output logic [DNUM_W-1:0]          out_dnum,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic                       seq_err,
  input  logic                       clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [DNUM_W-1:0] dnum;
    logic [DOUT_W-1:0] dout;
  } ent_t;

  typedef enum logic {IDLE, TRACK} st_t;

  ent_t          mem [DEPTH];
  ent_t          in_ent, head_q, head_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0] level_q, lvl_nxt;
  logic          full, push, pop, drop;
  st_t           st_q, st_nxt;
  logic [DNUM_W-1:0] exp_q, exp_nxt;
  logic          err_set;

  assign in_ent    = '{dnum: in_dnum, dout: in_dout};
  assign full      = (level_q == LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && !push;
  assign rd_nxt    = rd_ptr + AW'(pop);
  assign lvl_nxt   = level_q + LW'(push) - LW'(pop);

  assign out_dout  = head_q.dout;
  assign out_dnum  = head_q.dnum;
  assign level     = level_q;

  // Head register is the next entry to present; it holds its last value when empty.
  always_comb begin
    head_nxt = head_q;
    if (lvl_nxt != '0) begin
      if (push && (wr_ptr == rd_nxt)) head_nxt = in_ent;
      else                            head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      head_q  <= '0;
      ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_nxt;
      level_q <= lvl_nxt;
      head_q  <= head_nxt;
      if (drop)     ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end

  // Tracker sees every core word, accepted or dropped; mismatches resync exp.
  always_comb begin
    st_nxt  = st_q;
    exp_nxt = exp_q;
    err_set = 1'b0;
    if (in_valid) begin
      exp_nxt = in_dnum + DNUM_W'(1);
      st_nxt  = TRACK;
      if (st_q == TRACK && in_dnum != exp_q) err_set = 1'b1;
    end
    if (clr) begin
      st_nxt  = IDLE;
      err_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      exp_q   <= '0;
      seq_err <= 1'b0;
    end else begin
      st_q    <= st_nxt;
      exp_q   <= exp_nxt;
      if (clr)          seq_err <= 1'b0;
      else if (err_set) seq_err <= 1'b1;
    end
  end
endmodule
